tile_rom_arbiter: RTL
=====================

# tile_rom_arbiter

Shares one synchronous tile/sprite ROM (registered address, 1-cycle read latency, 3-bit palette index out) among several pixel-pipeline requesters, e.g. background tile mapper, sprite mapper, HUD overlay. Per-beat round-robin arbitration with a valid/ready request handshake and a tagged, fixed-latency response. Sits between the mapper front-ends and the single ROM instance, ahead of the palette lookup.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 15, ROM address width
- DATA_W, 3, ROM word width (palette index)
- vga_clk  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_last  in  NUM_REQ  final beat of a burst (used only with TILE_ARB_BURST_EN)
- req_ready  out  NUM_REQ  one-hot grant; beat accepted when valid&ready
- rsp_valid  out  NUM_REQ  one-hot; read data for requester i is on rsp_data
- rsp_data  out  DATA_W  ROM word, registered passthrough of rom_q
- rom_address  out  ADDR_W  to ROM address port
- rom_q  in  DATA_W  from ROM data port

## Operation
- Priority pointer ptr (clog2(NUM_REQ) bits) resets to 0. Each cycle, winner = first i with req_valid[i] scanning ptr, ptr+1, … wrapping modulo NUM_REQ.
- req_ready is combinational: one-hot on winner, all zero if no req_valid, and all zero while reset_n low.
- rom_address = req_addr of winner, combinational; 0 when no grant.
- On accepted beat to i: ptr <= (i+1) mod NUM_REQ; in-flight tag register <= {1, i}.
- Tag stage: in cycle after acceptance, rsp_valid[tag] = 1 and rsp_data = rom_q. No response backpressure; requesters must sink the data.
- At most one ROM read per cycle; back-to-back grants to different or same requester allowed every cycle.
- A requester dropping req_valid before grant loses nothing; there is no queuing inside the block.
- Unused/garbage addresses are not checked; ROM wraps naturally.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_data 0, rom_address 0, ptr 0, state IDLE, tag invalid.
- Latency: request accepted in cycle N -> rsp_valid in cycle N+1 (ROM registers address at end of N).
- Throughput: 1 beat/cycle aggregate.
- Reset asserted mid-operation: in-flight tag discarded immediately (rsp_valid drops asynchronously); no response is ever issued for it after reset release.
- Simultaneous requests: ptr decides; a requester continuously requesting with all others active is granted once every NUM_REQ cycles (no starvation).
- Single active requester: granted every cycle regardless of ptr.

## Configuration
- TILE_ARB_BURST_EN defined: two-state FSM IDLE/LOCKED. In IDLE a grant to i with req_last[i]=0 moves to LOCKED with owner=i; in LOCKED only owner may be granted (others see ready 0), owner gaps (req_valid low) hold the lock; accepted beat with req_last[owner]=1 returns to IDLE and sets ptr = owner+1. Beat with req_last=1 from IDLE stays IDLE.
- Not defined: req_last ignored, FSM absent, pure per-beat round-robin.

## Structure
- Package tile_rom_arb_pkg: arb_state_t enum (ARB_IDLE, ARB_LOCKED), default NUM_REQ/ADDR_W/DATA_W constants, tag struct {valid, idx}.
- Sub-module rr_picker: combinational (req vector, ptr) -> one-hot grant + index; no state.

## Test plan
- Reset: hold reset_n low with req_valid=4'b1111 -> req_ready 0, rsp_valid 0, rom_address 0.
- Single requester: req 2 valid, addr 0x0123, one cycle -> req_ready=4'b0100, rom_address 0x0123; next cycle rsp_valid=4'b0100, rsp_data = ROM[0x0123].
- Fairness: all four valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; each rsp_valid one cycle after its grant.
- Mid-flight reset: grant req 1 in cycle N, pulse reset_n low before edge N+1 -> no rsp_valid in N+1; after release ptr=0.
- Burst (TILE_ARB_BURST_EN): req 3 sends 4 beats, req_last on 4th, req 0 valid throughout -> req 0 ready only after 4th beat; next grant to req 0.
- Burst compiled out: same stimulus -> grants alternate 3,0,3,0.

Source files
------------

// File: rtl/tile_rom_arb_pkg.sv
// Shared types and default sizing for the tile ROM arbiter.
package tile_rom_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_DATA_W  = 3;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } arb_tag_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    logic [PTR_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Per-beat round-robin arbiter sharing one synchronous tile ROM among pixel requesters.
// TILE_ARB_BURST_EN adds a lock that keeps the grant on one requester until its req_last beat.
module tile_rom_arbiter
    import tile_rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_ptr;
    arb_tag_t           r_tag;
    logic [NUM_REQ-1:0] w_req_eff;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;

`ifdef TILE_ARB_BURST_EN
    arb_state_t         r_state;
    logic [PTR_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] w_owner_mask;

    always_comb begin
        w_owner_mask          = '0;
        w_owner_mask[r_owner] = 1'b1;
    end

    // While locked, only the owner competes; its idle gaps keep the lock.
    assign w_req_eff = !reset_n                ? '0 :
                       (r_state == ARB_LOCKED) ? (req_valid & w_owner_mask) :
                                                 req_valid;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else if (w_any) begin
            case (r_state)
                ARB_IDLE: begin
                    if (!req_last[w_idx]) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (req_last[w_idx]) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_req_eff     = reset_n ? req_valid : '0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready   = w_grant;
    assign rom_address = w_any ? req_addr[w_idx*ADDR_W +: ADDR_W] : '0;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_tag <= '0;
        end else begin
            r_tag.valid <= w_any;
            r_tag.idx   <= TAG_IDX_W'(w_idx);
            if (w_any) begin
                r_ptr <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // The ROM registered the winning address last cycle, so rom_q belongs to the tagged requester.
    assign rsp_valid = r_tag.valid ? (NUM_REQ'(1) << r_tag.idx) : '0;
    assign rsp_data  = r_tag.valid ? rom_q : '0;

endmodule
